int_request_ctrl: RTL and testbench
===================================

Name: int_request_ctrl

Overview:
- Requester side of the interrupt handshake for the Kabeta pipeline.
- Synchronises two asynchronous external interrupt lines, edge-detects them and holds them as pending flags.
- Applies a software mask and presents one stable request (IRQ_Int, IID_Sync) to the branch/exception controller.
- Clears the served pending flag when the controller acknowledges that it has taken the interrupt vector.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in each external-line synchroniser (legal values 2..4).
- MASK_RST, 2'b11, reset value of the interrupt mask register; bit n=1 enables line n.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- IrqIn  input  2  asynchronous external interrupt lines; rising-edge sensitive; bit 0 = INT_0, bit 1 = INT_1.
- IntAck  input  1  one-cycle pulse from top level; high in the cycle the exception controller selects an interrupt vector (ExcAckEX qualified by the interrupt branch).
- MaskWrEn  input  1  mask register write strobe.
- MaskWrData  input  2  new mask value.
- IRQ_Int  output  1  interrupt request to the exception controller.
- IID_Sync  output  1  ID of the presented request; 0 selects EV_INT_0, 1 selects EV_INT_1.
- Pending  output  2  raw pending flags, readable by software.
- Mask  output  2  current mask register.

Behaviour:
- Reset, asynchronous while Reset=1:
  - all synchroniser and previous-value flops = 0;
  - Pending=2'b00, Mask=MASK_RST;
  - state=IDLE, IRQ_Int=0, IID_Sync=0.
- Synchroniser and edge detect:
  - each IrqIn bit passes through SYNC_STAGES flops, then one previous-value flop;
  - Edge[n] = sync_out[n] & ~prev[n], combinational.
- Pending update, per bit, every edge:
  - the bit is set when Edge[n]=1;
  - the bit is cleared when the clear condition for n holds;
  - set and clear in the same cycle: set wins, so the line re-pends and no edge is lost;
  - a level held high produces exactly one pending set; a new rising edge is required to pend again.
- Mask register:
  - Mask <= MaskWrData when MaskWrEn=1;
  - masking never clears Pending.
- Eligible = Pending & Mask.
- Priority: line 0 is higher than line 1. Sel = 0 if Eligible[0], else 1.
- FSM, registered outputs:
  - IDLE: IRQ_Int=0. If Eligible≠0, go to REQ and latch CurId<=Sel. IID_Sync drives CurId.
  - REQ: IRQ_Int=1 and IID_Sync=CurId, held stable; no preemption by a higher-priority arrival.
    - IntAck=1: clear Pending[CurId] on the same edge, go to GAP.
    - Mask[CurId] cleared without IntAck: return to IDLE, pending retained.
    - IntAck and mask clear in the same cycle: IntAck wins.
  - GAP: IRQ_Int=0 for exactly one cycle, so the controller cannot re-take during its flush. Then go to IDLE.
- IntAck outside REQ is ignored and has no effect.
- Latency with SYNC_STAGES=2, IrqIn rising before edge 1:
  - Edge asserted after edge 2;
  - Pending set at edge 3;
  - IRQ_Int=1 after edge 4.
  - General form: IRQ_Int rises SYNC_STAGES+2 edges after the input transition.
- Back-to-back requests: after IntAck, the next eligible request reaches IRQ_Int no earlier than 2 edges later (GAP then IDLE→REQ).
- Reset mid-operation: all state returns to reset values immediately; requests in flight are discarded.

Test Plan:
1. Reset, then pulse IrqIn[1] for 3 cycles with SYNC_STAGES=2 → Pending=2'b10 after edge 3; IRQ_Int=1 and IID_Sync=1 after edge 4; both held until IntAck. IntAck → Pending=2'b00, IRQ_Int=0 for one GAP cycle, then stays IDLE.
2. Raise IrqIn[0] and IrqIn[1] in the same cycle → presents IID_Sync=0 first. After IntAck and GAP, presents IID_Sync=1 two edges after the ack. After the second ack, Pending=2'b00.
3. IrqIn[1] request in REQ, then IrqIn[0] edge arrives → IID_Sync stays 1 (no preemption) until IntAck; then ID 0 is served.
4. MaskWrData=2'b00 written while in REQ → IRQ_Int=0 next cycle, Pending unchanged. Rewrite Mask=2'b11 → IRQ_Int re-asserts one edge later with the same ID.
5. Inject a new IrqIn[0] edge whose Edge coincides with the IntAck for ID 0 → Pending[0] remains 1, and a second request for ID 0 follows after GAP. Hold IrqIn high for 50 cycles → only one pend.
6. Assert Reset asynchronously between clock edges while in REQ → IRQ_Int, Pending and IID_Sync go to 0 and Mask to 2'b11 without waiting for a clock edge. Deassert → IDLE.

Source files
------------

// File: rtl/int_request_ctrl.sv
// Purpose : requester side of the interrupt handshake; synchronises two async lines,
//           pends their rising edges, masks them and presents one stable request.
// Latency : IRQ_Int rises SYNC_STAGES+2 clock edges after an IrqIn rising transition.
// Backpr. : a presented request is held until IntAck (or until its mask bit drops);
//           new edges accumulate in Pending meanwhile and are never lost.
//
// Ports:
//   Clock, Reset      - system clock, asynchronous active-high reset
//   IrqIn[1:0]        - asynchronous external interrupt lines (rising-edge sensitive)
//   IntAck            - one-cycle pulse: controller has taken the interrupt vector
//   MaskWrEn/MaskWrData - software mask write strobe / value (bit n=1 enables line n)
//   IRQ_Int, IID_Sync - registered request and its ID (0 -> EV_INT_0, 1 -> EV_INT_1)
//   Pending, Mask     - raw pending flags and current mask, for software readback
module int_request_ctrl #(
  parameter int         SYNC_STAGES = 2,   // legal range 2..4
  parameter logic [1:0] MASK_RST    = 2'b11
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] IrqIn,
  input  logic       IntAck,
  input  logic       MaskWrEn,
  input  logic [1:0] MaskWrData,
  output logic       IRQ_Int,
  output logic       IID_Sync,
  output logic [1:0] Pending,
  output logic [1:0] Mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Element 0 of sync_q is the first synchroniser stage for both lines.
  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] mask_q, mask_d;
  state_t     state_q, state_d;
  logic       cur_q, cur_d;
  logic       irq_q, irq_d;

  logic [1:0] edge_det;
  logic [1:0] clr;
  logic [1:0] eligible;
  logic       sel;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], IrqIn};
    prev_d   = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Only an acknowledged request clears its own flag; IntAck elsewhere is ignored.
    clr = 2'b00;
    if (state_q == REQ && IntAck) begin
      clr = cur_q ? 2'b10 : 2'b01;
    end
    // Set after clear: an edge coinciding with the ack re-pends the line.
    pend_d = (pend_q & ~clr) | edge_det;

    mask_d = MaskWrEn ? MaskWrData : mask_q;

    eligible = pend_q & mask_q;
    sel      = ~eligible[0];   // line 0 has priority
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: begin
        if (eligible != 2'b00) begin
          state_d = REQ;
          cur_d   = sel;
        end
      end
      REQ: begin
        // ID is frozen while requesting: no preemption by a later line-0 edge.
        if (IntAck) begin
          state_d = GAP;
        end else if (!mask_q[cur_q]) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        // One dead cycle so the controller cannot re-take during its flush.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == REQ);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q  <= '0;
      prev_q  <= 2'b00;
      pend_q  <= 2'b00;
      mask_q  <= MASK_RST;
      state_q <= IDLE;
      cur_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      cur_q   <= cur_d;
      irq_q   <= irq_d;
    end
  end

  assign IRQ_Int  = irq_q;
  assign IID_Sync = cur_q;
  assign Pending  = pend_q;
  assign Mask     = mask_q;

endmodule

// File: tb/tb_int_request_ctrl.sv
module tb_int_request_ctrl;

  localparam int         S    = 2;
  localparam logic [1:0] MRST = 2'b11;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] IrqIn = 2'b00;
  logic       IntAck = 1'b0;
  logic       MaskWrEn = 1'b0;
  logic [1:0] MaskWrData = 2'b00;
  logic       IRQ_Int;
  logic       IID_Sync;
  logic [1:0] Pending;
  logic [1:0] Mask;

  int n_cmp = 0;
  int n_err = 0;

  int_request_ctrl #(.SYNC_STAGES(S), .MASK_RST(MRST)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .IrqIn     (IrqIn),
    .IntAck    (IntAck),
    .MaskWrEn  (MaskWrEn),
    .MaskWrData(MaskWrData),
    .IRQ_Int   (IRQ_Int),
    .IID_Sync  (IID_Sync),
    .Pending   (Pending),
    .Mask      (Mask)
  );

  always #5 Clock = ~Clock;

  // Reference model: h[k] holds the IrqIn value sampled k+1 edges ago, so the
  // synchronised value is h[S-1] and the value one edge older is h[S].
  logic [1:0] h [0:S];
  logic [1:0] m_pend, m_mask;
  logic       m_busy, m_gap, m_cur;

  typedef struct {
    logic [1:0] irq_in;
    logic       ack;
    logic       wen;
    logic [1:0] wdat;
    logic       e_irq;
    logic       e_iid;
    logic [1:0] e_pend;
    logic [1:0] e_mask;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] i, logic a, logic w, logic [1:0] wd,
                              logic eq, logic ei, logic [1:0] ep, logic [1:0] em);
    vec_t v;
    v.irq_in = i; v.ack = a; v.wen = w; v.wdat = wd;
    v.e_irq = eq; v.e_iid = ei; v.e_pend = ep; v.e_mask = em;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= S; i++) h[i] = 2'b00;
    m_pend = 2'b00;
    m_mask = MRST;
    m_busy = 1'b0;
    m_gap  = 1'b0;
    m_cur  = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] ev, elig, clr;
    if (Reset) begin
      model_reset();
      return;
    end
    ev   = h[S-1] & ~h[S];
    elig = m_pend & m_mask;
    clr  = 2'b00;
    if (m_busy) begin
      if (IntAck) begin
        clr[m_cur] = 1'b1;
        m_busy = 1'b0;
        m_gap  = 1'b1;
      end else if (!m_mask[m_cur]) begin
        m_busy = 1'b0;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (elig != 2'b00) begin
      m_busy = 1'b1;
      m_cur  = elig[0] ? 1'b0 : 1'b1;
    end
    m_pend = (m_pend & ~clr) | ev;
    if (MaskWrEn) m_mask = MaskWrData;
    for (int i = S; i > 0; i--) h[i] = h[i-1];
    h[0] = IrqIn;
  endtask

  task automatic model_check();
    chk("mdl_irq",  {7'b0, IRQ_Int},  {7'b0, m_busy});
    chk("mdl_iid",  {7'b0, IID_Sync}, {7'b0, m_cur});
    chk("mdl_pend", {6'b0, Pending},  {6'b0, m_pend});
    chk("mdl_mask", {6'b0, Mask},     {6'b0, m_mask});
  endtask

  // Drive inputs, take one rising edge, advance the model, compare 1 ns later.
  task automatic step(logic [1:0] ii, logic a, logic w, logic [1:0] wd);
    IrqIn = ii; IntAck = a; MaskWrEn = w; MaskWrData = wd;
    @(posedge Clock);
    model_edge();
    #1;
    model_check();
  endtask

  initial begin
    logic [1:0] rin;
    int         rises;

    // ---------------- reset state ----------------
    model_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_irq",  {7'b0, IRQ_Int},  8'h0);
    chk("rst_iid",  {7'b0, IID_Sync}, 8'h0);
    chk("rst_pend", {6'b0, Pending},  8'h0);
    chk("rst_mask", {6'b0, Mask},     {6'b0, MRST});
    Reset = 1'b0;

    // ---------------- table: single line, dual line, mask drop/restore ----------------
    //                 in     ack  wen  wdat   irq  iid  pend   mask
    tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00));
    tbl.push_back(mk(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00));
    tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11));

    foreach (tbl[k]) begin
      step(tbl[k].irq_in, tbl[k].ack, tbl[k].wen, tbl[k].wdat);
      chk($sformatf("tbl%0d_irq", k),  {7'b0, IRQ_Int},  {7'b0, tbl[k].e_irq});
      chk($sformatf("tbl%0d_iid", k),  {7'b0, IID_Sync}, {7'b0, tbl[k].e_iid});
      chk($sformatf("tbl%0d_pend", k), {6'b0, Pending},  {6'b0, tbl[k].e_pend});
      chk($sformatf("tbl%0d_mask", k), {6'b0, Mask},     {6'b0, tbl[k].e_mask});
    end

    // ---------------- no preemption by a later line-0 edge ----------------
    repeat (4) step(2'b10, 1'b0, 1'b0, 2'b00);
    chk("np_irq", {7'b0, IRQ_Int},  8'h1);
    chk("np_iid", {7'b0, IID_Sync}, 8'h1);
    repeat (5) step(2'b11, 1'b0, 1'b0, 2'b00);
    chk("np_hold_irq",  {7'b0, IRQ_Int},  8'h1);
    chk("np_hold_iid",  {7'b0, IID_Sync}, 8'h1);
    chk("np_hold_pend", {6'b0, Pending},  8'h3);
    step(2'b11, 1'b1, 1'b0, 2'b00);
    chk("np_ack_irq",  {7'b0, IRQ_Int}, 8'h0);
    chk("np_ack_pend", {6'b0, Pending}, 8'h1);
    step(2'b11, 1'b0, 1'b0, 2'b00);
    step(2'b11, 1'b0, 1'b0, 2'b00);
    chk("np_id0_irq", {7'b0, IRQ_Int},  8'h1);
    chk("np_id0_iid", {7'b0, IID_Sync}, 8'h0);
    step(2'b11, 1'b1, 1'b0, 2'b00);
    chk("np_done_pend", {6'b0, Pending}, 8'h0);

    // ---------------- edge coincident with ack re-pends; held level pends once ----------------
    repeat (4) step(2'b00, 1'b0, 1'b0, 2'b00);
    repeat (4) step(2'b01, 1'b0, 1'b0, 2'b00);
    chk("co_req_irq", {7'b0, IRQ_Int},  8'h1);
    chk("co_req_iid", {7'b0, IID_Sync}, 8'h0);
    repeat (4) step(2'b00, 1'b0, 1'b0, 2'b00);
    step(2'b01, 1'b0, 1'b0, 2'b00);
    step(2'b01, 1'b0, 1'b0, 2'b00);
    step(2'b01, 1'b1, 1'b0, 2'b00);
    chk("co_ack_pend", {6'b0, Pending}, 8'h1);
    chk("co_ack_irq",  {7'b0, IRQ_Int}, 8'h0);
    step(2'b01, 1'b0, 1'b0, 2'b00);
    chk("co_idle_irq", {7'b0, IRQ_Int}, 8'h0);
    step(2'b01, 1'b0, 1'b0, 2'b00);
    chk("co_re_irq", {7'b0, IRQ_Int},  8'h1);
    chk("co_re_iid", {7'b0, IID_Sync}, 8'h0);
    step(2'b01, 1'b1, 1'b0, 2'b00);
    rises = 0;
    for (int c = 0; c < 50; c++) begin
      step(2'b01, 1'b0, 1'b0, 2'b00);
      if (IRQ_Int) rises++;
    end
    chk("lvl_irq_cycles", rises[7:0],         8'h0);
    chk("lvl_pend",       {6'b0, Pending},    8'h0);

    // ---------------- asynchronous reset while requesting ----------------
    repeat (4) step(2'b00, 1'b0, 1'b0, 2'b00);
    step(2'b00, 1'b0, 1'b1, 2'b10);
    repeat (4) step(2'b11, 1'b0, 1'b0, 2'b00);
    chk("ar_pre_irq",  {7'b0, IRQ_Int},  8'h1);
    chk("ar_pre_iid",  {7'b0, IID_Sync}, 8'h1);
    chk("ar_pre_pend", {6'b0, Pending},  8'h3);
    chk("ar_pre_mask", {6'b0, Mask},     8'h2);
    #2;
    Reset = 1'b1;
    #1;
    chk("ar_irq",  {7'b0, IRQ_Int},  8'h0);
    chk("ar_iid",  {7'b0, IID_Sync}, 8'h0);
    chk("ar_pend", {6'b0, Pending},  8'h0);
    chk("ar_mask", {6'b0, Mask},     {6'b0, MRST});
    model_reset();
    step(2'b00, 1'b0, 1'b0, 2'b00);
    Reset = 1'b0;
    repeat (3) step(2'b00, 1'b0, 1'b0, 2'b00);
    chk("ar_post_irq", {7'b0, IRQ_Int}, 8'h0);

    // ---------------- randomized traffic against the model ----------------
    rin = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      rin[0] = rin[0] ^ ($urandom_range(0, 7) == 0);
      rin[1] = rin[1] ^ ($urandom_range(0, 7) == 0);
      step(rin,
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
